// File: rtl/detector_jogada.sv
// -----------------------------------------------------------------------------
// detector_jogada
//
// Player-input front end for the game controller. The five raw buttons are
// synchronised, debounced, and each accepted press produces a one-cycle
// ocorreu_jogada pulse. The accepted pattern (jogada) and the fire flag
// (ocorreu_tiro) are held, so the downstream controller can sample them
// several cycles after the pulse.
//
// Parameters:
//   DEBOUNCE_CYCLES - cycles a pattern (pressed or released) must stay stable
//   REPEAT_CYCLES   - auto-repeat period while a press is held
//                     (only with DETECTOR_JOGADA_REPEAT_EN)
//
// Ports:
//   clock          in   rising-edge clock
//   reset          in   asynchronous, active-low reset
//   botoes[4:0]    in   raw buttons, asynchronous; [3:0] directions, [4] fire
//   habilita       in   detection enable (level)
//   limpa_tiro     in   synchronous clear of ocorreu_tiro
//   ocorreu_jogada out  one-cycle pulse per accepted press
//   jogada[4:0]    out  last accepted pattern, held
//   ocorreu_tiro   out  fire bit of last accepted press, held until cleared
//   db_estado[2:0] out  FSM state code (7 while in an illegal state)
//
// Optional feature:
//   `define DETECTOR_JOGADA_REPEAT_EN enables auto-repeat of a held press.
//   Without it, exactly one pulse is produced per press.
// -----------------------------------------------------------------------------
module detector_jogada #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned REPEAT_CYCLES   = 250000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [4:0] botoes,
  input  logic       habilita,
  input  logic       limpa_tiro,
  output logic       ocorreu_jogada,
  output logic [4:0] jogada,
  output logic       ocorreu_tiro,
  output logic [2:0] db_estado
);

  // One shared counter, wide enough for the larger of the two periods.
  localparam int unsigned MaxCycles = (DEBOUNCE_CYCLES > REPEAT_CYCLES) ?
                                      DEBOUNCE_CYCLES : REPEAT_CYCLES;
  localparam int unsigned CntW      = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;

  localparam logic [CntW-1:0] DebLast = CntW'(DEBOUNCE_CYCLES - 1);
`ifdef DETECTOR_JOGADA_REPEAT_EN
  localparam logic [CntW-1:0] RepLast = CntW'(REPEAT_CYCLES - 1);
`endif

  typedef enum logic [2:0] {
    StEspera      = 3'd0,
    StFiltra      = 3'd1,
    StSinaliza    = 3'd2,
    StEsperaSolta = 3'd3
  } estado_t;

  // ---------------------------------------------------------------------------
  // Input synchroniser
  // ---------------------------------------------------------------------------
  logic [4:0] r_sync1;
  logic [4:0] r_sync2;
  logic [4:0] w_botoes_s;
  logic       w_zero;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= botoes;
      r_sync2 <= r_sync1;
    end
  end

  assign w_botoes_s = r_sync2;
  assign w_zero     = (w_botoes_s == 5'd0);

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  estado_t         r_estado;
  estado_t         w_prox_estado;
  logic [CntW-1:0] r_cnt;
  logic [CntW-1:0] w_prox_cnt;
  logic [CntW-1:0] w_cnt_base;
  logic [4:0]      r_candidato;
  logic [4:0]      w_prox_candidato;
  logic            w_carrega;
  logic [4:0]      r_jogada;
  logic            r_tiro;

`ifdef DETECTOR_JOGADA_REPEAT_EN
  // In ESPERA_SOLTA the counter serves both the release count and the repeat
  // count. When the input switches between released and held, the count
  // restarts so one phase never inherits the other's progress.
  logic r_era_zero;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_era_zero <= 1'b1;
    end else begin
      r_era_zero <= w_zero;
    end
  end

  assign w_cnt_base = (w_zero != r_era_zero) ? '0 : r_cnt;
`else
  // Any nonzero sample clears the count, so the release phase always starts
  // from zero on its own.
  assign w_cnt_base = r_cnt;
`endif

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_estado <= StEspera;
    end else begin
      r_estado <= w_prox_estado;
    end
  end

  // Counter, candidate pattern and held outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt       <= '0;
      r_candidato <= '0;
      r_jogada    <= '0;
      r_tiro      <= 1'b0;
    end else begin
      r_cnt       <= w_prox_cnt;
      r_candidato <= w_prox_candidato;
      if (w_carrega) begin
        // Load takes precedence over a simultaneous limpa_tiro.
        r_jogada <= r_candidato;
        r_tiro   <= r_candidato[4];
      end else if (limpa_tiro) begin
        r_tiro <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_prox_estado    = r_estado;
    w_prox_cnt       = r_cnt;
    w_prox_candidato = r_candidato;
    w_carrega        = 1'b0;

    if (!habilita) begin
      w_prox_estado = StEspera;
      w_prox_cnt    = '0;
    end else begin
      case (r_estado)
        StEspera: begin
          w_prox_cnt = '0;
          if (!w_zero) begin
            w_prox_candidato = w_botoes_s;
            w_prox_estado    = StFiltra;
          end
        end

        StFiltra: begin
          if (w_zero) begin
            w_prox_estado = StEspera;
            w_prox_cnt    = '0;
          end else if (w_botoes_s != r_candidato) begin
            // Pattern changed mid-debounce: restart on the new pattern.
            w_prox_candidato = w_botoes_s;
            w_prox_cnt       = '0;
          end else if (r_cnt == DebLast) begin
            w_prox_estado = StSinaliza;
            w_prox_cnt    = '0;
            w_carrega     = 1'b1;
          end else begin
            w_prox_cnt = r_cnt + 1'b1;
          end
        end

        StSinaliza: begin
          w_prox_cnt    = '0;
          w_prox_estado = StEsperaSolta;
        end

        StEsperaSolta: begin
          if (w_zero) begin
            if (w_cnt_base == DebLast) begin
              w_prox_estado = StEspera;
              w_prox_cnt    = '0;
            end else begin
              w_prox_cnt = w_cnt_base + 1'b1;
            end
          end else begin
`ifdef DETECTOR_JOGADA_REPEAT_EN
            if (w_botoes_s == r_candidato) begin
              if (w_cnt_base == RepLast) begin
                w_prox_estado = StSinaliza;
                w_prox_cnt    = '0;
                w_carrega     = 1'b1;
              end else begin
                w_prox_cnt = w_cnt_base + 1'b1;
              end
            end else begin
              w_prox_candidato = w_botoes_s;
              w_prox_cnt       = '0;
              w_prox_estado    = StFiltra;
            end
`else
            w_prox_cnt = '0;
`endif
          end
        end

        default: begin
          w_prox_estado = StEspera;
          w_prox_cnt    = '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    ocorreu_jogada = 1'b0;
    db_estado      = 3'd7;
    case (r_estado)
      StEspera:      db_estado = 3'd0;
      StFiltra:      db_estado = 3'd1;
      StSinaliza: begin
        db_estado      = 3'd2;
        ocorreu_jogada = habilita;
      end
      StEsperaSolta: db_estado = 3'd3;
      default:       db_estado = 3'd7;
    endcase
  end

  assign jogada       = r_jogada;
  assign ocorreu_tiro = r_tiro;

endmodule

// File: doc/detector_jogada.md
# detector_jogada

Player-input front end for the main game controller. Synchronises and debounces the five game buttons, and emits a one-cycle `ocorreu_jogada` pulse per accepted press. It holds the accepted button pattern in `jogada` and the shot flag in `ocorreu_tiro` so the controller can sample them several cycles after the pulse. It sits directly upstream of `uc_jogo_principal`, which consumes `ocorreu_jogada` and `ocorreu_tiro`.

## Interface
- `DEBOUNCE_CYCLES`, default 50000 — cycles an input pattern must stay stable, pressed or released, to be accepted.
- `REPEAT_CYCLES`, default 250000 — auto-repeat period while a press is held; used only with `DETECTOR_JOGADA_REPEAT_EN`.
- `clock` input 1 — single clock, rising edge.
- `reset` input 1 — asynchronous, active-low; 0 clears all state.
- `botoes` input 5 — raw buttons. [3:0] are directions (up/down/left/right); [4] is fire. Asynchronous to `clock`.
- `habilita` input 1 — detection enable; level.
- `limpa_tiro` input 1 — synchronous clear of `ocorreu_tiro`.
- `ocorreu_jogada` output 1 — one-cycle pulse per accepted press.
- `jogada` output 5 — last accepted pattern; held.
- `ocorreu_tiro` output 1 — `jogada[4]` of the last accepted press; held until cleared.
- `db_estado` output 3 — FSM state code.

## Operation
- `botoes` passes through a 2-flop synchroniser; the result is `botoes_s`.
- Internal registers:
  - `candidato[4:0]`;
  - one counter sized to `$clog2` of the larger parameter.
- States:
  - ESPERA (0): if `botoes_s != 0`, load `candidato <= botoes_s`, clear counter, go to FILTRA.
  - FILTRA (1):
    - if `botoes_s == 0`, go to ESPERA;
    - else if `botoes_s != candidato`, reload `candidato` and clear counter;
    - else if counter == `DEBOUNCE_CYCLES`-1, go to SINALIZA and on the same edge load `jogada <= candidato`, `ocorreu_tiro <= candidato[4]`;
    - else increment counter.
  - SINALIZA (2): `ocorreu_jogada` = 1 (Moore output); clear counter; go to ESPERA_SOLTA unconditionally.
  - ESPERA_SOLTA (3):
    - if `botoes_s == 0`, count; at `DEBOUNCE_CYCLES`-1 go to ESPERA;
    - any nonzero `botoes_s` clears the release count (repeat behaviour: see Configuration).
  - Codes 4–7 are illegal; go to ESPERA. `db_estado` = 7 while in an illegal state.
- `habilita` = 0:
  - next state is ESPERA from any state; counter cleared;
  - no pulse is generated;
  - `jogada` and `ocorreu_tiro` hold their values.
- `limpa_tiro` = 1 clears `ocorreu_tiro` on the next edge. On the FILTRA→SINALIZA load edge, the load wins.
- Pressing more than one button simultaneously is legal; the whole 5-bit pattern is reported. No priority encoding.

## Timing
- Reset values:
  - state ESPERA;
  - `ocorreu_jogada` 0, `jogada` 0, `ocorreu_tiro` 0;
  - `db_estado` 0;
  - synchroniser 0, counter 0.
- Latency:
  - a stable press first seen at edge k appears in `botoes_s` after edge k+2;
  - FILTRA is entered at edge k+3;
  - SINALIZA is entered at edge k+3+`DEBOUNCE_CYCLES`;
  - `ocorreu_jogada` is high for exactly one cycle after that edge.
- `jogada` and `ocorreu_tiro` are valid in the same cycle as the pulse. They remain stable at least until the next SINALIZA, which comes no sooner than `DEBOUNCE_CYCLES`+2 cycles later. This covers the controller sampling `ocorreu_tiro` 3 cycles after the pulse.
- A glitch shorter than `DEBOUNCE_CYCLES` cycles produces no pulse.
- Reset asserted mid-debounce or mid-pulse aborts immediately; no pulse after release of reset unless a new full debounce completes.

## Configuration
- `DETECTOR_JOGADA_REPEAT_EN` defined, in ESPERA_SOLTA:
  - if `botoes_s == candidato`, the counter runs; at `REPEAT_CYCLES`-1 go to SINALIZA and re-emit the same pattern. This reloads `jogada` and `ocorreu_tiro` as on the FILTRA→SINALIZA edge.
  - if `botoes_s` is nonzero and differs from `candidato`, reload `candidato`, clear counter, go to FILTRA.
- Undefined: nonzero `botoes_s` in ESPERA_SOLTA only clears the release count. Exactly one pulse per press; the buttons must be released for `DEBOUNCE_CYCLES` cycles before the next press is detected.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, `REPEAT_CYCLES`=8, `habilita`=1 unless stated.
- Reset low, then high; idle 10 cycles → all outputs 0, `db_estado`=0.
- `botoes`=5'b00100 held from edge k → single `ocorreu_jogada` pulse in the cycle after edge k+7; `jogada`=00100, `ocorreu_tiro`=0; no further pulse while held (macro off).
- `botoes`=5'b10001 held 6 cycles, released → one pulse; `jogada`=10001; `ocorreu_tiro`=1 and still 1 three cycles later. Assert `limpa_tiro` one cycle → `ocorreu_tiro`=0 on the next edge.
- `botoes`=00010 for 2 cycles, then 0 → no pulse; `db_estado` returns to 0.
- `habilita`=0 while holding `botoes`=01000 for 20 cycles → no pulse, `db_estado`=0. Raise `habilita` → pulse 4+1 cycles later; `reset`=0 during FILTRA → no pulse.
- Macro on: hold `botoes`=00001 for 30 cycles → first pulse at edge k+7, then every 9 cycles (SINALIZA + 8 repeat cycles).
